// File: rtl/demux4_rr_dispatch_if.sv
// Bundle of the producer handshake, lane-side handshake and status signals of demux4_rr_dispatch.
// The master view is the dispatcher; the slave view is its surrounding producer/consumers.
interface demux4_rr_dispatch_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [3:0]       lane_en;
  logic [3:0]       out_ready;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic [1:0]       last_lane;
  logic [15:0]      dispatch_cnt;

  modport master (
    input  in_valid, in_data, lane_en, out_ready,
    output in_ready, out_valid, out_data, sel, last_lane, dispatch_cnt
  );

  modport slave (
    output in_valid, in_data, lane_en, out_ready,
    input  in_ready, out_valid, out_data, sel, last_lane, dispatch_cnt
  );
endinterface

// File: rtl/demux4_rr_dispatch.sv
// One-entry buffered 1-to-4 dispatcher: each held word goes to one enabled, ready lane
// chosen with rotating priority starting at the lane after the last one served.
module demux4_rr_dispatch #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  demux4_rr_dispatch_if.master   bus
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hold_data;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_last_lane;
  logic [15:0]      r_dispatch_cnt;

  logic [3:0]       w_elig;
  logic             w_found;
  logic [1:0]       w_gnt_idx;
  logic [1:0]       w_scan;
  logic             w_dispatch;
  logic             w_in_ready;
  logic             w_accept;

  assign w_elig = bus.lane_en & bus.out_ready & {4{r_state == S_FULL}};

  // Scan from the round-robin pointer; with no grant the select rests on the pointer.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = r_rr_ptr;
    w_scan    = r_rr_ptr;
    for (int k = 0; k < 4; k++) begin
      w_scan = r_rr_ptr + 2'(k);
      if (!w_found && w_elig[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_dispatch = |w_elig;
  assign w_in_ready = reset_n & ((r_state == S_EMPTY) | w_dispatch);
  assign w_accept   = bus.in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (w_dispatch && !w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold_data    <= '0;
      r_rr_ptr       <= 2'd0;
      r_last_lane    <= 2'd0;
      r_dispatch_cnt <= 16'd0;
    end else begin
      if (w_accept) r_hold_data <= bus.in_data;
      if (w_dispatch) begin
        r_rr_ptr       <= w_gnt_idx + 2'd1;
        r_last_lane    <= w_gnt_idx;
        r_dispatch_cnt <= r_dispatch_cnt + 16'd1;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_found ? (4'b0001 << w_gnt_idx) : 4'b0000;
  assign bus.out_data     = r_hold_data;
  assign bus.sel          = w_gnt_idx;
  assign bus.last_lane    = r_last_lane;
  assign bus.dispatch_cnt = r_dispatch_cnt;

endmodule

// File: tb/tb_demux4_rr_dispatch.sv
// Directed bench for demux4_rr_dispatch: reset, streaming, masking, backpressure,
// wrap-around grant, mid-operation reset and dispatch counter wrap.
module tb_demux4_rr_dispatch;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errs   = 0;

  demux4_rr_dispatch_if #(.WIDTH(8)) bus ();

  demux4_rr_dispatch #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] words [4];
  logic [1:0] lanes [4];
  int         bad;
  int         seen;

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.lane_en   = 4'hF;
    bus.out_ready = 4'hF;

    // Reset held for two edges with the producer already presenting a word
    tick();
    tick();
    chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_cnt",       32'(bus.dispatch_cnt), 32'd0);
    chk("rst_out_data",  32'(bus.out_data), 32'd0);
    chk("rst_sel",       32'(bus.sel), 32'd0);
    chk("rst_last",      32'(bus.last_lane), 32'd0);

    // Back-to-back stream over all lanes
    reset_n = 1'b1;
    #1;
    chk("empty_in_ready", 32'(bus.in_ready), 32'd1);
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", 32'(bus.out_valid), 32'(4'b0001 << i));
      chk("stream_data",  32'(bus.out_data), 32'(words[i]));
      chk("stream_ready", 32'(bus.in_ready), 32'd1);
      if (i < 3) bus.in_data = words[i+1];
      else       bus.in_valid = 1'b0;
      tick();
    end
    chk("stream_cnt",   32'(bus.dispatch_cnt), 32'd4);
    chk("stream_last",  32'(bus.last_lane), 32'd3);
    chk("stream_idle",  32'(bus.out_valid), 32'd0);
    chk("stream_rrptr", 32'(bus.sel), 32'd0);

    // Masked rotation: lanes 1 and 3 only
    bus.lane_en  = 4'b1010;
    bus.in_valid = 1'b1;
    words[0] = 8'hA0; words[1] = 8'hA1; words[2] = 8'hA2; words[3] = 8'hA3;
    lanes[0] = 2'd1;  lanes[1] = 2'd3;  lanes[2] = 2'd1;  lanes[3] = 2'd3;
    bus.in_data = words[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("mask_valid", 32'(bus.out_valid), 32'(4'b0001 << lanes[i]));
      chk("mask_sel",   32'(bus.sel), 32'(lanes[i]));
      chk("mask_data",  32'(bus.out_data), 32'(words[i]));
      if (i < 3) bus.in_data = words[i+1];
      else       bus.in_valid = 1'b0;
      tick();
    end
    chk("mask_cnt",   32'(bus.dispatch_cnt), 32'd8);
    chk("mask_last",  32'(bus.last_lane), 32'd3);
    chk("mask_rrptr", 32'(bus.sel), 32'd0);

    // Backpressure: word waits with no lane ready
    bus.lane_en   = 4'hF;
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_data",  32'(bus.out_data), 32'hA5);
      tick();
    end
    bus.out_ready = 4'b0100;
    #1;
    chk("bp_rel_valid", 32'(bus.out_valid), 32'b0100);
    chk("bp_rel_sel",   32'(bus.sel), 32'd2);
    chk("bp_rel_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_cnt",   32'(bus.dispatch_cnt), 32'd9);
    chk("bp_last",  32'(bus.last_lane), 32'd2);
    chk("bp_idle",  32'(bus.out_valid), 32'd0);
    chk("bp_rrptr", 32'(bus.sel), 32'd3);

    // Lane skipping: only lane 0 ready, pointer at 3 then at 1
    bus.out_ready = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hB1 + 8'(i);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("skip_valid", 32'(bus.out_valid), 32'b0001);
      chk("skip_sel",   32'(bus.sel), 32'd0);
      tick();
      chk("skip_rrptr", 32'(bus.sel), 32'd1);
      chk("skip_cnt",   32'(bus.dispatch_cnt), 32'(10 + i));
      chk("skip_last",  32'(bus.last_lane), 32'd0);
    end

    // Reset mid-operation discards the held word
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("mid_hold", 32'(bus.out_data), 32'h5A);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    tick();
    reset_n       = 1'b1;
    bus.out_ready = 4'hF;
    #1;
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_cnt",   32'(bus.dispatch_cnt), 32'd0);
    chk("mid_data",  32'(bus.out_data), 32'd0);
    chk("mid_sel",   32'(bus.sel), 32'd0);
    tick();
    chk("mid_valid2", 32'(bus.out_valid), 32'd0);
    chk("mid_cnt2",   32'(bus.dispatch_cnt), 32'd0);

    // Counter wrap: 65536 dispatches streamed one per cycle
    bad  = 0;
    seen = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (bus.out_valid != (4'b0001 << (i % 4))) bad++;
      if (bus.out_data != 8'(i)) bad++;
      if (bus.in_ready != 1'b1) bad++;
      if (bus.out_valid != 4'b0000) seen++;
      if (i < 65535) bus.in_data = 8'(i + 1);
      else           bus.in_valid = 1'b0;
    end
    chk("wrap_stream_errs", 32'(bad), 32'd0);
    chk("wrap_seen",        32'(seen), 32'd65536);
    chk("wrap_cnt_max",     32'(bus.dispatch_cnt), 32'hFFFF);
    tick();
    chk("wrap_cnt",   32'(bus.dispatch_cnt), 32'd0);
    chk("wrap_last",  32'(bus.last_lane), 32'd3);
    chk("wrap_idle",  32'(bus.out_valid), 32'd0);
    chk("wrap_ready", 32'(bus.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
